// File: rtl/xocc_mq_pkg.sv
// Shared encodings for the XOCC multi-queue bridge: decode bit positions,
// rs2 field layout and sticky error bit indices.
package xocc_mq_pkg;

   localparam int WORD_W = 32;

   localparam int FUNC_NORM = 0;
   localparam int FUNC_DLY  = 1;

   localparam int SUB_PUSH_RDY = 0;
   localparam int SUB_POP_RDY  = 1;
   localparam int SUB_READ_RSP = 2;
   localparam int SUB_OCC      = 3;
   localparam int SUB_ERR      = 4;

   localparam int SUB_PUSH_CMD  = 0;
   localparam int SUB_WRITE_CMD = 1;
   localparam int SUB_POP_RSP   = 2;

   localparam int RS2_QID_LSB = 0;
   localparam int RS2_QID_W   = 4;
   localparam int RS2_FID_LSB = 4;
   localparam int RS2_FID_W   = 8;
   localparam int RS2_CLR_BIT = 12;

   localparam int ERR_RSP_OVF  = 0;
   localparam int ERR_CMD_UDF  = 1;
   localparam int ERR_PUSH_REJ = 2;
   localparam int ERR_W        = 3;

endpackage

// File: rtl/xocc_mq_fifo.sv
// Single-clock first-word-fall-through FIFO; the head reads as zero while empty.
module xocc_mq_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             forever_cpuclk,
   input  logic             xocc_rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_wr;
   logic             do_rd;

   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);
   // Full/empty come from the pre-edge count, so a write at full or a read at
   // empty is dropped even when the opposite side moves on the same edge.
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;

   always_ff @(posedge forever_cpuclk or posedge xocc_rst) begin
      if (xocc_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];
   assign count   = cnt;

endmodule

// File: rtl/rv_1_pa_iu_xocc_mq.sv
// IU XOCC multi-queue bridge: EX1 XOCC ops to NUM_CH DSA command/response FIFOs.
// Optional per-channel sticky error bits enabled by defining XOCC_MQ_ERR_STICKY_EN.
module rv_1_pa_iu_xocc_mq
   import xocc_mq_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CMD_WORDS = 3,
   parameter int RSP_WORDS = 2,
   parameter int DEPTH     = 16,
   parameter int CNT_W     = $clog2(DEPTH) + 1
) (
   input  logic                                 forever_cpuclk,
   input  logic                                 xocc_rst,
   input  logic                                 idu_iu_ex1_inst_vld,
   input  logic                                 idu_iu_ex1_xocc_sel,
   input  logic [4:0]                           idu_xocc_ex1_func,
   input  logic [4:0]                           idu_xocc_ex1_sub_func,
   input  logic [31:0]                          idu_xocc_ex1_rs1,
   input  logic [31:0]                          idu_xocc_ex1_rs2,
   output logic                                 iu_rtu_ex1_xocc_cmplt,
   output logic [31:0]                          iu_rtu_ex1_xocc_data,
   output logic [NUM_CH*CMD_WORDS*WORD_W-1:0]   dsa_cmd_data,
   output logic [NUM_CH-1:0]                    dsa_cmd_vld,
   input  logic [NUM_CH-1:0]                    dsa_cmd_rd_en,
   input  logic [NUM_CH*RSP_WORDS*WORD_W-1:0]   dsa_rsp_data,
   input  logic [NUM_CH-1:0]                    dsa_rsp_wr_en,
   output logic [NUM_CH-1:0]                    dsa_rsp_full
);
   localparam int CMD_W = CMD_WORDS * WORD_W;
   localparam int RSP_W = RSP_WORDS * WORD_W;

   logic                 norm_sel, dly_sel;
   logic                 push_op, write_op, pop_op;
   logic [4:0]           sub;
   logic [RS2_QID_W-1:0] qid;
   logic [RS2_FID_W-1:0] fid;
   logic                 clr_on_push;
   logic [NUM_CH-1:0]    hit, cmd_full, cmd_empty, rsp_full, rsp_empty;
   logic [NUM_CH-1:0]    push_go, push_rej, pop_go;
   logic [CNT_W-1:0]     cmd_cnt [NUM_CH];
   logic [CNT_W-1:0]     rsp_cnt [NUM_CH];
   logic [RSP_W-1:0]     rsp_head [NUM_CH];
   logic [ERR_W-1:0]     err [NUM_CH];
   logic [31:0]          res;
   logic                 unused_bits;

   assign sub         = idu_xocc_ex1_sub_func;
   assign norm_sel    = idu_xocc_ex1_func[FUNC_NORM] & idu_iu_ex1_xocc_sel;
   assign dly_sel     = idu_xocc_ex1_func[FUNC_DLY] & idu_iu_ex1_xocc_sel & idu_iu_ex1_inst_vld;
   assign push_op     = dly_sel & sub[SUB_PUSH_CMD];
   assign write_op    = dly_sel & sub[SUB_WRITE_CMD];
   assign pop_op      = dly_sel & sub[SUB_POP_RSP];
   assign qid         = idu_xocc_ex1_rs2[RS2_QID_LSB +: RS2_QID_W];
   assign fid         = idu_xocc_ex1_rs2[RS2_FID_LSB +: RS2_FID_W];
   assign clr_on_push = idu_xocc_ex1_rs2[RS2_CLR_BIT];
   assign unused_bits = ^{idu_xocc_ex1_func[4:2], idu_xocc_ex1_rs2[31:13], push_rej};

   assign iu_rtu_ex1_xocc_cmplt = idu_iu_ex1_inst_vld
                                  & (|(idu_xocc_ex1_func & {5{idu_iu_ex1_xocc_sel}}));

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CMD_W-1:0] stg, stg_nxt;

      // Out-of-range queue ids match no channel, so they touch no state.
      assign hit[c]      = (qid == RS2_QID_W'(c));
      assign push_go[c]  = push_op & hit[c] & ~cmd_full[c];
      assign push_rej[c] = push_op & hit[c] & cmd_full[c];
      assign pop_go[c]   = pop_op & hit[c] & ~rsp_empty[c];

      always_comb begin
         stg_nxt = stg;
         if (push_go[c] && clr_on_push) stg_nxt = '0;
         if (write_op && hit[c]) begin
            for (int w = 0; w < CMD_WORDS; w++) begin
               if (fid == RS2_FID_W'(w)) stg_nxt[w*WORD_W +: WORD_W] = idu_xocc_ex1_rs1;
            end
         end
      end

      always_ff @(posedge forever_cpuclk or posedge xocc_rst) begin
         if (xocc_rst) stg <= '0;
         else          stg <= stg_nxt;
      end

      xocc_mq_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_cmd_fifo (
         .forever_cpuclk (forever_cpuclk),
         .xocc_rst       (xocc_rst),
         .wr_en          (push_go[c]),
         .wr_data        (stg),
         .rd_en          (dsa_cmd_rd_en[c]),
         .rd_data        (dsa_cmd_data[c*CMD_W +: CMD_W]),
         .full           (cmd_full[c]),
         .empty          (cmd_empty[c]),
         .count          (cmd_cnt[c])
      );

      xocc_mq_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rsp_fifo (
         .forever_cpuclk (forever_cpuclk),
         .xocc_rst       (xocc_rst),
         .wr_en          (dsa_rsp_wr_en[c]),
         .wr_data        (dsa_rsp_data[c*RSP_W +: RSP_W]),
         .rd_en          (pop_go[c]),
         .rd_data        (rsp_head[c]),
         .full           (rsp_full[c]),
         .empty          (rsp_empty[c]),
         .count          (rsp_cnt[c])
      );

`ifdef XOCC_MQ_ERR_STICKY_EN
      logic [ERR_W-1:0] err_q, err_new;
      logic             err_clr;

      always_comb begin
         err_new               = '0;
         err_new[ERR_RSP_OVF]  = dsa_rsp_wr_en[c] & rsp_full[c];
         err_new[ERR_CMD_UDF]  = dsa_cmd_rd_en[c] & cmd_empty[c];
         err_new[ERR_PUSH_REJ] = push_rej[c];
      end

      assign err_clr = norm_sel & idu_iu_ex1_inst_vld & sub[SUB_ERR] & hit[c];

      // A fresh error on the clearing edge survives the clear.
      always_ff @(posedge forever_cpuclk or posedge xocc_rst) begin
         if (xocc_rst) err_q <= '0;
         else          err_q <= (err_clr ? '0 : err_q) | err_new;
      end

      assign err[c] = err_q;
`else
      assign err[c] = '0;
`endif
   end

   assign dsa_cmd_vld  = ~cmd_empty;
   assign dsa_rsp_full = rsp_full;

   always_comb begin
      res = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (hit[c]) begin
            if (norm_sel && sub[SUB_PUSH_RDY]) res |= {31'b0, ~cmd_full[c]};
            if (norm_sel && sub[SUB_POP_RDY])  res |= {31'b0, ~rsp_empty[c]};
            if (norm_sel && sub[SUB_READ_RSP]) begin
               for (int w = 0; w < RSP_WORDS; w++) begin
                  if (fid == RS2_FID_W'(w)) res |= rsp_head[c][w*WORD_W +: WORD_W];
               end
            end
            if (norm_sel && sub[SUB_OCC]) res |= {16'(cmd_cnt[c]), 16'(rsp_cnt[c])};
            if (norm_sel && sub[SUB_ERR]) res |= {{(WORD_W-ERR_W){1'b0}}, err[c]};
            if (push_go[c]) res |= 32'd1;
            if (pop_go[c])  res |= 32'd1;
         end
      end
      if (write_op) res |= 32'd1;
   end

   assign iu_rtu_ex1_xocc_data = res;

endmodule

// File: tb/tb_rv_1_pa_iu_xocc_mq.sv
// Self-checking bench for rv_1_pa_iu_xocc_mq: vector table plus command scoreboard.
module tb_rv_1_pa_iu_xocc_mq;
   localparam int NUM_CH = 4, CMD_WORDS = 3, RSP_WORDS = 2, DEPTH = 16, CNT_W = 5;
   localparam int CW = CMD_WORDS * 32;
   localparam int RW = RSP_WORDS * 32;
   localparam logic [4:0] F_N = 5'b00001, F_D = 5'b00010;
   localparam logic [4:0] S0 = 5'd1, S1 = 5'd2, S2 = 5'd4, S3 = 5'd8, S4 = 5'd16;
`ifdef XOCC_MQ_ERR_STICKY_EN
   localparam logic [31:0] ERR_ONE = 32'd1, ERR_TWO = 32'd2;
`else
   localparam logic [31:0] ERR_ONE = 32'd0, ERR_TWO = 32'd0;
`endif

   logic                   forever_cpuclk = 1'b0;
   logic                   xocc_rst;
   logic                   idu_iu_ex1_inst_vld, idu_iu_ex1_xocc_sel;
   logic [4:0]             idu_xocc_ex1_func, idu_xocc_ex1_sub_func;
   logic [31:0]            idu_xocc_ex1_rs1, idu_xocc_ex1_rs2;
   logic                   iu_rtu_ex1_xocc_cmplt;
   logic [31:0]            iu_rtu_ex1_xocc_data;
   logic [NUM_CH*CW-1:0]   dsa_cmd_data;
   logic [NUM_CH-1:0]      dsa_cmd_vld, dsa_cmd_rd_en;
   logic [NUM_CH*RW-1:0]   dsa_rsp_data;
   logic [NUM_CH-1:0]      dsa_rsp_wr_en, dsa_rsp_full;

   rv_1_pa_iu_xocc_mq #(.NUM_CH(NUM_CH), .CMD_WORDS(CMD_WORDS), .RSP_WORDS(RSP_WORDS),
                        .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .forever_cpuclk        (forever_cpuclk),
      .xocc_rst              (xocc_rst),
      .idu_iu_ex1_inst_vld   (idu_iu_ex1_inst_vld),
      .idu_iu_ex1_xocc_sel   (idu_iu_ex1_xocc_sel),
      .idu_xocc_ex1_func     (idu_xocc_ex1_func),
      .idu_xocc_ex1_sub_func (idu_xocc_ex1_sub_func),
      .idu_xocc_ex1_rs1      (idu_xocc_ex1_rs1),
      .idu_xocc_ex1_rs2      (idu_xocc_ex1_rs2),
      .iu_rtu_ex1_xocc_cmplt (iu_rtu_ex1_xocc_cmplt),
      .iu_rtu_ex1_xocc_data  (iu_rtu_ex1_xocc_data),
      .dsa_cmd_data          (dsa_cmd_data),
      .dsa_cmd_vld           (dsa_cmd_vld),
      .dsa_cmd_rd_en         (dsa_cmd_rd_en),
      .dsa_rsp_data          (dsa_rsp_data),
      .dsa_rsp_wr_en         (dsa_rsp_wr_en),
      .dsa_rsp_full          (dsa_rsp_full)
   );

   always #5 forever_cpuclk = ~forever_cpuclk;

   typedef struct {
      logic [4:0]  f;
      logic [4:0]  s;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] exp;
      string       nm;
   } vec_t;

   vec_t            tbl [14];
   int              n_vec = 0;
   int              n_err = 0;
   logic [CW-1:0]   cmd_sb [$];

   function automatic logic [31:0] rs2f(input int q, input int fd, input bit clr);
      return {19'b0, clr, 8'(fd), 4'(q)};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr_in();
      idu_iu_ex1_inst_vld   = 1'b0;
      idu_iu_ex1_xocc_sel   = 1'b0;
      idu_xocc_ex1_func     = '0;
      idu_xocc_ex1_sub_func = '0;
      idu_xocc_ex1_rs1      = '0;
      idu_xocc_ex1_rs2      = '0;
      dsa_cmd_rd_en         = '0;
      dsa_rsp_wr_en         = '0;
   endtask

   // One EX1 instruction; DSA strobes set beforehand apply on the same edge.
   task automatic exec(input logic [4:0] f, input logic [4:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input string nm);
      @(negedge forever_cpuclk);
      idu_iu_ex1_inst_vld   = 1'b1;
      idu_iu_ex1_xocc_sel   = 1'b1;
      idu_xocc_ex1_func     = f;
      idu_xocc_ex1_sub_func = s;
      idu_xocc_ex1_rs1      = a;
      idu_xocc_ex1_rs2      = b;
      #2;
      check(nm, 128'(iu_rtu_ex1_xocc_data), 128'(exp));
      check({nm, "_cmplt"}, 128'(iu_rtu_ex1_xocc_cmplt), 128'(f != 5'd0));
      @(posedge forever_cpuclk);
      #1;
      clr_in();
   endtask

   task automatic dsa_idle();
      @(posedge forever_cpuclk);
      #1;
      clr_in();
   endtask

   task automatic head_chk(input int c, input string nm);
      logic [CW-1:0] e;
      if (cmd_sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: scoreboard empty, got head %0h", nm, dsa_cmd_data[c*CW +: CW]);
      end else begin
         e = cmd_sb.pop_front();
         check({nm, "_vld"}, 128'(dsa_cmd_vld[c]), 128'(1));
         check(nm, 128'(dsa_cmd_data[c*CW +: CW]), 128'(e));
      end
   endtask

   task automatic pop_cmd(input int c, input string nm);
      @(negedge forever_cpuclk);
      head_chk(c, nm);
      dsa_cmd_rd_en[c] = 1'b1;
      @(posedge forever_cpuclk);
      #1;
      clr_in();
   endtask

   initial begin
      clr_in();
      dsa_rsp_data = '0;
      xocc_rst = 1'b0;
      #1 xocc_rst = 1'b1;
      #2;
      check("rst_cmd_vld", 128'(dsa_cmd_vld), 128'(0));
      check("rst_rsp_full", 128'(dsa_rsp_full), 128'(0));
      check("rst_cmd_data", 128'(dsa_cmd_data == '0), 128'(1));
      @(negedge forever_cpuclk);
      xocc_rst = 1'b0;
      @(posedge forever_cpuclk);
      #1;

      tbl[0]  = '{F_N,  S0, 32'h0,    rs2f(1, 0, 0), 32'd1,         "push_rdy_q1"};
      tbl[1]  = '{F_N,  S1, 32'h0,    rs2f(1, 0, 0), 32'd0,         "pop_rdy_q1"};
      tbl[2]  = '{F_N,  S3, 32'h0,    rs2f(1, 0, 0), 32'd0,         "occ_q1_init"};
      tbl[3]  = '{F_D,  S1, 32'hA0,   rs2f(1, 0, 0), 32'd1,         "wr_q1_w0"};
      tbl[4]  = '{F_D,  S1, 32'hA1,   rs2f(1, 1, 0), 32'd1,         "wr_q1_w1"};
      tbl[5]  = '{F_D,  S1, 32'hA2,   rs2f(1, 2, 0), 32'd1,         "wr_q1_w2"};
      tbl[6]  = '{F_D,  S0, 32'h0,    rs2f(1, 0, 0), 32'd1,         "push_q1"};
      tbl[7]  = '{F_N,  S3, 32'h0,    rs2f(1, 0, 0), 32'h0001_0000, "occ_q1_one"};
      tbl[8]  = '{F_D,  S0, 32'h0,    rs2f(5, 0, 0), 32'd0,         "push_bad_q"};
      tbl[9]  = '{F_D,  S1, 32'hDEAD, rs2f(5, 0, 0), 32'd1,         "wr_bad_q"};
      tbl[10] = '{F_D,  S1, 32'hBEEF, rs2f(1, 5, 0), 32'd1,         "wr_bad_fid"};
      tbl[11] = '{F_N,  S2, 32'h0,    rs2f(2, 3, 0), 32'd0,         "rd_bad_fid"};
      tbl[12] = '{F_N,  S3, 32'h0,    rs2f(0, 0, 0), 32'd0,         "occ_q0_init"};
      tbl[13] = '{5'd0, S0, 32'h0,    rs2f(1, 0, 0), 32'd0,         "no_sel"};
      foreach (tbl[i]) exec(tbl[i].f, tbl[i].s, tbl[i].rs1, tbl[i].rs2, tbl[i].exp, tbl[i].nm);

      // Staging, push and read-out; invalid writes must not have disturbed q1.
      check("vld_after_tbl", 128'(dsa_cmd_vld), 128'(4'b0010));
      check("q1_slice", 128'(dsa_cmd_data[CW +: CW]), 128'({32'hA2, 32'hA1, 32'hA0}));
      exec(F_D, S0, 32'h0, rs2f(1, 0, 0), 32'd1, "push_q1_again");
      cmd_sb.push_back({32'hA2, 32'hA1, 32'hA0});
      cmd_sb.push_back({32'hA2, 32'hA1, 32'hA0});
      pop_cmd(1, "q1_pop0");
      pop_cmd(1, "q1_pop1");
      check("q1_vld_drained", 128'(dsa_cmd_vld[1]), 128'(0));

      // Fill q0 to full, then try a push with a concurrent DSA read.
      for (int i = 0; i < DEPTH; i++) begin
         exec(F_D, S1, 32'(i + 1), rs2f(0, 0, 0), 32'd1, "fill_wr");
         exec(F_D, S0, 32'h0, rs2f(0, 0, 0), 32'd1, "fill_push");
         cmd_sb.push_back({64'h0, 32'(i + 1)});
      end
      exec(F_D, S0, 32'h0, rs2f(0, 0, 0), 32'd0, "push_full");
      exec(F_N, S0, 32'h0, rs2f(0, 0, 0), 32'd0, "push_rdy_full");
      exec(F_N, S3, 32'h0, rs2f(0, 0, 0), 32'h0010_0000, "occ_full");
      head_chk(0, "full_head");
      dsa_cmd_rd_en[0] = 1'b1;
      exec(F_D, S0, 32'h0, rs2f(0, 0, 0), 32'd0, "push_full_rd");
      exec(F_N, S3, 32'h0, rs2f(0, 0, 0), 32'h000F_0000, "occ_15");
      for (int i = 0; i < DEPTH - 1; i++) pop_cmd(0, "drain_q0");
      exec(F_N, S3, 32'h0, rs2f(0, 0, 0), 32'd0, "occ_q0_empty");

      // Response path on q2.
      dsa_rsp_data[2*RW +: RW] = {32'h22, 32'h11};
      dsa_rsp_wr_en[2] = 1'b1;
      dsa_idle();
      exec(F_N, S1, 32'h0, rs2f(2, 0, 0), 32'd1, "pop_rdy_q2");
      exec(F_N, S2, 32'h0, rs2f(2, 1, 0), 32'h22, "rd_q2_f1");
      exec(F_N, S2, 32'h0, rs2f(2, 0, 0), 32'h11, "rd_q2_f0");
      exec(F_D, S2, 32'h0, rs2f(2, 0, 0), 32'd1, "pop_q2");
      exec(F_N, S1, 32'h0, rs2f(2, 0, 0), 32'd0, "pop_rdy_q2_empty");
      exec(F_N, S2, 32'h0, rs2f(2, 1, 0), 32'd0, "rd_q2_empty");
      exec(F_D, S2, 32'h0, rs2f(5, 0, 0), 32'd0, "pop_bad_q");
      dsa_rsp_data[2*RW +: RW] = {32'h44, 32'h33};
      dsa_rsp_wr_en[2] = 1'b1;
      exec(F_D, S2, 32'h0, rs2f(2, 0, 0), 32'd0, "pop_empty_wr");
      exec(F_N, S2, 32'h0, rs2f(2, 0, 0), 32'h33, "rd_q2_new");
      exec(F_N, S3, 32'h0, rs2f(2, 0, 0), 32'h0000_0001, "occ_q2");

      // Clear-on-push with simultaneous pops across pointer wrap on q3.
      for (int i = 0; i < 40; i++) begin
         exec(F_D, S1, 32'h100 + 32'(i), rs2f(3, 0, 0), 32'd1, "wrap_w0");
         exec(F_D, S1, 32'h900 + 32'(i), rs2f(3, 2, 0), 32'd1, "wrap_w2");
         if (cmd_sb.size() > 0) begin
            head_chk(3, "wrap_head");
            dsa_cmd_rd_en[3] = 1'b1;
         end
         exec(F_D, S0, 32'h0, rs2f(3, 0, 1), 32'd1, "wrap_push");
         cmd_sb.push_back({32'h900 + 32'(i), 32'h0, 32'h100 + 32'(i)});
         if (i % 10 == 9) begin
            exec(F_D, S0, 32'h0, rs2f(3, 0, 0), 32'd1, "push_cleared");
            cmd_sb.push_back('0);
         end
      end
      exec(F_N, S3, 32'h0, rs2f(3, 0, 0), 32'h0005_0000, "occ_q3");
      for (int i = 0; i < 5; i++) pop_cmd(3, "drain_q3");

      // Reset mid-fill discards FIFOs and the staged command.
      exec(F_D, S1, 32'h55, rs2f(1, 0, 0), 32'd1, "stage_q1");
      for (int i = 0; i < 3; i++) exec(F_D, S0, 32'h0, rs2f(0, 0, 0), 32'd1, "prefill_q0");
      @(negedge forever_cpuclk);
      #2 xocc_rst = 1'b1;
      #1;
      check("mid_rst_vld", 128'(dsa_cmd_vld), 128'(0));
      check("mid_rst_data", 128'(dsa_cmd_data == '0), 128'(1));
      @(negedge forever_cpuclk);
      xocc_rst = 1'b0;
      @(posedge forever_cpuclk);
      #1;
      cmd_sb.delete();
      exec(F_N, S3, 32'h0, rs2f(0, 0, 0), 32'd0, "occ_q0_rst");
      exec(F_N, S3, 32'h0, rs2f(2, 0, 0), 32'd0, "occ_q2_rst");
      exec(F_D, S0, 32'h0, rs2f(1, 0, 0), 32'd1, "push_q1_rst");
      cmd_sb.push_back('0);
      pop_cmd(1, "q1_lost_stage");

      // DSA read of an empty command FIFO is ignored (and flagged when enabled).
      dsa_cmd_rd_en[0] = 1'b1;
      exec(F_N, S3, 32'h0, rs2f(0, 0, 0), 32'd0, "occ_rd_empty");
      exec(F_N, S3, 32'h0, rs2f(0, 0, 0), 32'd0, "occ_after_rd_empty");
      exec(F_N, S4, 32'h0, rs2f(0, 0, 0), ERR_TWO, "err_udf");
      exec(F_N, S4, 32'h0, rs2f(0, 0, 0), 32'd0, "err_udf_cleared");

      // Response FIFO overflow on q0.
      for (int i = 0; i < DEPTH; i++) begin
         dsa_rsp_data[0 +: RW] = {32'h400 + 32'(i), 32'h300 + 32'(i)};
         dsa_rsp_wr_en[0] = 1'b1;
         dsa_idle();
      end
      check("rsp_full_q0", 128'(dsa_rsp_full), 128'(4'b0001));
      dsa_rsp_data[0 +: RW] = {32'hDEAD, 32'hDEAD};
      dsa_rsp_wr_en[0] = 1'b1;
      dsa_idle();
      exec(F_N, S3, 32'h0, rs2f(0, 0, 0), 32'h0000_0010, "occ_rsp_full");
      exec(F_N, S2, 32'h0, rs2f(0, 0, 0), 32'h300, "rd_head_after_ovf");
      exec(F_N, S4, 32'h0, rs2f(0, 0, 0), ERR_ONE, "err_ovf");
      dsa_rsp_wr_en[0] = 1'b1;
      exec(F_N, S4, 32'h0, rs2f(0, 0, 0), 32'd0, "err_clr_vs_new");
      exec(F_N, S4, 32'h0, rs2f(0, 0, 0), ERR_ONE, "err_new_wins");
      exec(F_N, S4, 32'h0, rs2f(0, 0, 0), 32'd0, "err_ovf_cleared");
      for (int i = 0; i < DEPTH; i++) begin
         exec(F_N, S2, 32'h0, rs2f(0, 1, 0), 32'h400 + 32'(i), "rsp_order");
         exec(F_D, S2, 32'h0, rs2f(0, 0, 0), 32'd1, "rsp_pop");
      end
      exec(F_N, S1, 32'h0, rs2f(0, 0, 0), 32'd0, "pop_rdy_q0_done");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv_1_pa_iu_xocc_mq.md
Name: rv_1_pa_iu_xocc_mq

Overview:
- Parametrised successor of the IU XOCC queue bridge. Connects custom XOCC instructions in EX1 to NUM_CH DSA channels.
- Each channel has a command staging buffer, a command FIFO toward the DSA and a response FIFO from the DSA.
- Single clock domain. Channel count, word counts and FIFO depth are uniform across channels and set by parameters.
- New versus the previous generation: occupancy query, bounds-checked queue/field ids, and a push-with-clear mode.

Parameters:
- NUM_CH, 4, number of DSA channels (1..16).
- CMD_WORDS, 3, 32-bit words per command entry (1..16).
- RSP_WORDS, 2, 32-bit words per response entry (1..16).
- DEPTH, 16, entries per FIFO (power of two, >=2).
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- forever_cpuclk  in  1  sole clock.
- xocc_rst  in  1  reset; asynchronous, active-high.
- idu_iu_ex1_inst_vld  in  1  EX1 instruction valid.
- idu_iu_ex1_xocc_sel  in  1  instruction is XOCC.
- idu_xocc_ex1_func  in  5  [0]=norm class, [1]=dly class.
- idu_xocc_ex1_sub_func  in  5  operation one-hot within the class.
- idu_xocc_ex1_rs1  in  32  write data.
- idu_xocc_ex1_rs2  in  32  [3:0]=queue_id, [11:4]=field_id, [12]=clear-on-push.
- iu_rtu_ex1_xocc_cmplt  out  1  completion = inst_vld & |(func & {5{xocc_sel}}).
- iu_rtu_ex1_xocc_data  out  32  result.
- dsa_cmd_data  out  NUM_CH*CMD_WORDS*32  FWFT head of each command FIFO.
- dsa_cmd_vld  out  NUM_CH  command FIFO non-empty.
- dsa_cmd_rd_en  in  NUM_CH  DSA pops the command head.
- dsa_rsp_data  in  NUM_CH*RSP_WORDS*32  response write data.
- dsa_rsp_wr_en  in  NUM_CH  DSA pushes a response.
- dsa_rsp_full  out  NUM_CH  response FIFO full.

Behaviour:
- Reset (xocc_rst high, asynchronous): all FIFO pointers and counts 0, staging buffers 0, dsa_cmd_vld=0, dsa_rsp_full=0, dsa_cmd_data=0. Release is synchronous to forever_cpuclk.
- Decode. norm_sel=func[0]&xocc_sel; dly_sel=func[1]&xocc_sel&inst_vld.
- Valid ids: queue_id < NUM_CH. A field is valid if field_id < CMD_WORDS (write_cmd) or field_id < RSP_WORDS (read_rsp).
- Norm class, sub_func[0] push_rdy: {31'b0, ~cmd_full[q]}.
- Norm class, sub_func[1] pop_rdy: {31'b0, ~rsp_empty[q]}.
- Norm class, sub_func[2] read_rsp: word field_id of the response head. Returns 0 if the FIFO is empty or the id is invalid.
- Norm class, sub_func[3] occupancy: {cmd_cnt[q] zero-extended in [31:16], rsp_cnt[q] zero-extended in [15:0]}.
- Dly class, sub_func[0] push_cmd: if the id is valid and the FIFO is not full, enqueue staging[q] at the clock edge and return 1; otherwise return 0 and change nothing. If rs2[12]=1 and the push succeeds, staging[q] clears to 0 on the same edge.
- Dly class, sub_func[1] write_cmd: staging[q] word field_id <= rs1 at the edge; returns 1. Invalid ids are ignored but still return 1.
- Dly class, sub_func[2] pop_rsp: if not empty, dequeue and return 1; else return 0.
- Result: OR of the selected operation's value; 0 if nothing is selected. Purely combinational in EX1.
- Latency:
  - A push is visible on dsa_cmd_vld and dsa_cmd_data the cycle after the edge.
  - A DSA response write is visible on pop_rdy and read_rsp the cycle after its edge.
  - A pop updates the head the next cycle.
- Full/empty are evaluated on the pre-edge state:
  - push_cmd with the FIFO full fails even if dsa_cmd_rd_en is high in the same cycle.
  - pop_rsp with the FIFO empty fails even if dsa_rsp_wr_en is high in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged; pointers advance and wrap modulo DEPTH.
- dsa_cmd_rd_en while empty: ignored.
- dsa_rsp_wr_en while full: data dropped; the FIFO is unchanged.
- Reset asserted mid-operation discards all contents; a partially staged command is lost.

Optional Feature:
- XOCC_MQ_ERR_STICKY_EN defined: per-channel sticky error bits, 3 per channel:
  - [0] DSA wrote the response FIFO while full.
  - [1] DSA read the command FIFO while empty.
  - [2] push_cmd was rejected.
- norm sub_func[4] returns {29'b0, err[q]} and clears err[q] on the edge when inst_vld=1. A new error on the same edge takes priority over the clear. Reset value is 0.
- Undefined: no error register exists and sub_func[4] returns 0.

Decomposition:
- Package xocc_mq_pkg:
  - func/sub_func bit indices.
  - queue_id/field_id/clear bit positions in rs2.
  - WORD_W=32.
  - Error bit indices.
- One sub-module, xocc_mq_fifo: single-clock FWFT FIFO with parameters WIDTH and DEPTH.
  - Outputs full, empty, count.
  - Instantiated 2*NUM_CH times via generate.

Test Plan:
- Staging, push and read-out: write_cmd q=1 words 0..2 = 0xA0,0xA1,0xA2, then push_cmd q=1 -> returns 1; next cycle dsa_cmd_vld[1]=1 and the q1 slice = {0xA2,0xA1,0xA0}; occupancy = 0x0001_0000.
- Fill to full: 16 push_cmd on q=0 return 1 and the 17th returns 0; push_rdy=0. Push with simultaneous dsa_cmd_rd_en at full -> returns 0 and count becomes 15.
- Response path: DSA writes {0x22,0x11} on q=2 -> next cycle pop_rdy=1; read_rsp field 1 = 0x22; pop_rsp returns 1; next cycle pop_rdy=0 and read_rsp=0.
- Bounds: queue_id=5 with NUM_CH=4 -> push_cmd returns 0 and write_cmd returns 1 with no state change; read_rsp field 3 with RSP_WORDS=2 returns 0.
- Clear-on-push and wrap: 40 push/pop pairs with rs2[12]=1 -> after each push the staging buffer reads back 0; data order is preserved across pointer wrap.
- Reset and error bits: assert xocc_rst mid-fill -> all vld=0 and counts 0 immediately. With XOCC_MQ_ERR_STICKY_EN: a DSA write while full makes sub_func[4] return 1, and a second read returns 0.
